memwrite_tracer: RTL and testbench
==================================

# memwrite_tracer

Synthesizable store-trace capture stage that sits directly downstream of the single-cycle `mips` core, alongside `dmem`. It watches the core's `memwrite`/`aluout`/`writedata` bus and records every committed store, with a 1-based cycle stamp, into a FIFO. A checker drains the FIFO through a valid/ready port. The block also detects the finish PC and produces the core clock enable, so a run halts cleanly and back-pressures the core instead of losing stores.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pc`  in  32  core program counter.
- `memwrite`  in  1  core store strobe.
- `aluout`  in  32  store address.
- `writedata`  in  32  store data.
- `pc_finished`  in  32  halt address; held stable for the whole run.
- `cpu_en`  out  1  core clock enable; the core advances only on edges where this is high.
- `trace_valid`  out  1  FIFO head valid.
- `trace_ready`  in  1  consumer pops the head on an edge where `trace_valid & trace_ready`.
- `trace_cycle`  out  32  cycle stamp of the head entry.
- `trace_addr`  out  32  address of the head entry.
- `trace_data`  out  32  data of the head entry.
- `cycle_count`  out  32  number of enabled core cycles so far.
- `stall_count`  out  32  number of cycles the core was blocked by a full FIFO.
- `halted`  out  1  finish PC has been reached.
- `done`  out  1  halted and FIFO fully drained.

## Operation
- Combinational signals:
  - `fin = (pc == pc_finished)`.
  - `pop = trace_valid & trace_ready`.
  - `full = (count == DEPTH)`.
  - `blocked = memwrite & full & ~pop`.
  - `cpu_en = (state == RUN) & ~fin & ~blocked`.
- Push occurs on an edge where `memwrite & cpu_en`. The entry stored is {`cycle_count + 1`, `aluout`, `writedata`}.
- `cycle_count` increments on every edge with `cpu_en` high, so a store's stamp equals the new `cycle_count`.
- `stall_count` increments on edges where `state == RUN & ~fin & blocked`.
- FIFO behaviour:
  - Circular buffer with wrapping read/write pointers and occupancy `count` (0..DEPTH).
  - Push and pop on the same edge are both performed, including at full and at count 1; `count` is unchanged.
  - Pop when empty is impossible because `trace_valid` is 0.
  - Entries are never dropped and never reordered.
- Head outputs are show-ahead: `trace_*` present the oldest entry whenever `trace_valid` is high, and hold that entry until it is popped.
- State machine `state`, reset to RUN:
  - RUN → HALT on an edge with `fin` high. No push occurs on that edge even if `memwrite` is high; a store at the finish PC is masked.
  - HALT → DONE on an edge where `count == 0`, or where `count == 1 & pop`.
  - DONE is terminal until reset.
- Outputs derived from state: `halted = (state != RUN)`, `done = (state == DONE)`.
- In HALT and DONE, `cycle_count` and `stall_count` freeze. Pops remain legal in HALT.

## Timing
- Reset values, asserted asynchronously:
  - `state` = RUN; pointers, `count`, `cycle_count`, `stall_count` = 0.
  - Outputs: `trace_valid`=0, `halted`=0, `done`=0.
  - `trace_cycle`, `trace_addr`, `trace_data` = 0.
  - `cpu_en` is combinational and equals `~fin` while `memwrite` is low.
- Reset mid-run discards all FIFO contents and counters immediately, without waiting for a clock edge.
- Capture latency: a store pushed at edge N appears at the head (if the FIFO was empty) with `trace_valid` high after edge N, usable at edge N+1. There is no combinational path from push to `trace_valid`.
- `cpu_en` depends combinationally on `trace_ready`, so a full FIFO with a same-cycle pop does not stall.
- A finish reached with the FIFO already empty gives RUN→HALT at edge N and HALT→DONE at edge N+1.
- Counters wrap modulo 2^32 with no saturation.

## Test plan
- **Reset:** with `pc_finished`=0xFFFFFFFF and `pc`=0, apply `reset` mid-cycle → all outputs 0 immediately and `cpu_en`=1. Release reset → `cycle_count` counts 1, 2, 3 on successive edges.
- **Single store:** `memwrite`=1, `aluout`=0x54, `writedata`=0x7 on the third enabled edge → `trace_valid` rises after that edge with head {3, 0x54, 0x7}. `trace_ready`=1 → `trace_valid` drops after the pop edge.
- **Back-pressure:** `DEPTH`=4, `trace_ready`=0, five consecutive stores → four entries stored. On the fifth, `cpu_en`=0 and `stall_count` increments each cycle. Raise `trace_ready` → the fifth store is pushed on the same edge as the first pop, `count` stays 4, and order is preserved with stamps 1..5.
- **Finish masking:** `pc`==`pc_finished` with `memwrite`=1 → `cpu_en`=0 and no push. `halted`=1 after the edge. With 2 entries queued, `done` rises only on the edge that pops the last entry.
- **Wrap-around:** `DEPTH`=4, 10 stores interleaved with pops → all 10 emerge in order with correct address, data and stamp; `count` never exceeds 4.
- **Reset mid-operation:** assert `reset` while in HALT with 3 entries queued → FIFO empty, `state`=RUN, counters 0, and the next store gets stamp 1.

Source files
------------

// File: rtl/memwrite_tracer.sv
// Store-trace capture for the single-cycle mips core: queues every committed store
// with its cycle stamp, detects the finish PC and back-pressures the core via cpu_en.
module memwrite_tracer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic [31:0] pc_finished,
    output logic        cpu_en,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_cycle,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count,
    output logic        halted,
    output logic        done
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HALT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] cycle;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             fin;
    logic             pop;
    logic             full;
    logic             blocked;
    logic             push;

    assign fin         = (pc == pc_finished);
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    assign full        = (count == FULL_CNT);
    assign blocked     = memwrite & full & ~pop;
    assign cpu_en      = (state == RUN) & ~fin & ~blocked;
    assign push        = memwrite & cpu_en;
    assign halted      = (state != RUN);
    assign done        = (state == DONE);

    // Show-ahead head; forced to zero while empty so reset leaves the outputs clean
    always_comb begin
        head        = mem[rd_ptr];
        trace_cycle = '0;
        trace_addr  = '0;
        trace_data  = '0;
        if (trace_valid) begin
            trace_cycle = head.cycle;
            trace_addr  = head.addr;
            trace_data  = head.data;
        end
    end

    // Next-state logic: halt on finish PC, done once the queue has drained
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (fin) state_next = HALT;
            end
            HALT: begin
                if ((count == '0) || ((count == ONE_CNT) && pop)) state_next = DONE;
            end
            DONE: state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            if (cpu_en) cycle_count <= cycle_count + 32'd1;
            if ((state == RUN) && !fin && blocked) stall_count <= stall_count + 32'd1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible once counted in
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cycle_count + 32'd1, aluout, writedata};
    end

endmodule

// File: tb/tb_memwrite_tracer.sv
// Directed plus randomized bench for memwrite_tracer (DEPTH=4) against a queue-based
// model of the store trace, cycle/stall counters and run/halt/done phases.
module tb_memwrite_tracer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] writedata = '0;
    logic [31:0] pc_finished = 32'hFFFF_FFFF;
    logic        cpu_en;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_cycle;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [31:0] cycle_count;
    logic [31:0] stall_count;
    logic        halted;
    logic        done;

    memwrite_tracer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .memwrite(memwrite), .aluout(aluout),
        .writedata(writedata), .pc_finished(pc_finished), .cpu_en(cpu_en),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_cycle(trace_cycle),
        .trace_addr(trace_addr), .trace_data(trace_data), .cycle_count(cycle_count),
        .stall_count(stall_count), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_stalls;
    int          phase;     // 0 running, 1 halted draining, 2 finished
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        chk("trace_valid", 32'(trace_valid), 32'(q.size() > 0));
        if (q.size() > 0) h = q[0];
        else h = '{32'd0, 32'd0, 32'd0};
        chk("trace_cycle", trace_cycle, h.c);
        chk("trace_addr", trace_addr, h.a);
        chk("trace_data", trace_data, h.d);
        chk("cycle_count", cycle_count, m_cyc);
        chk("stall_count", stall_count, m_stalls);
        chk("halted", 32'(halted), 32'(phase != 0));
        chk("done", 32'(done), 32'(phase == 2));
    endtask

    // One clock: check cpu_en before the edge, advance the model, check outputs after
    task automatic step();
        ent_t e;
        int   sz;
        logic fin_now, pop_now, full_now, en_now, stall_now;
        #2;
        sz        = q.size();
        fin_now   = (pc == pc_finished);
        pop_now   = (sz > 0) && trace_ready;
        full_now  = (sz == int'(DEPTH));
        stall_now = memwrite && full_now && !pop_now;
        en_now    = (phase == 0) && !fin_now && !stall_now;
        chk("cpu_en", 32'(cpu_en), 32'(en_now));
        @(posedge clk);
        if (en_now) m_cyc = m_cyc + 32'd1;
        if ((phase == 0) && !fin_now && stall_now) m_stalls = m_stalls + 32'd1;
        if (pop_now) e = q.pop_front();
        if (memwrite && en_now) q.push_back('{m_cyc, aluout, writedata});
        if ((phase == 0) && fin_now) phase = 1;
        else if ((phase == 1) && (q.size() == 0)) phase = 2;
        #1;
        check_outputs();
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for an edge
    task automatic do_reset();
        reset = 1'b1;
        memwrite = 1'b0;
        #2;
        q.delete();
        m_cyc = '0;
        m_stalls = '0;
        phase = 0;
        check_outputs();
        chk("reset_cpu_en", 32'(cpu_en), 32'(pc != pc_finished));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        aluout = a;
        writedata = d;
        step();
    endtask

    initial begin
        m_cyc = '0;
        m_stalls = '0;
        phase = 0;

        // Reset and free-running cycle count
        do_reset();
        trace_ready = 1'b0;
        memwrite = 1'b0;
        step();
        chk("count_1", cycle_count, 32'd1);
        step();
        chk("count_2", cycle_count, 32'd2);

        // Single store on the third enabled edge, then popped
        store(32'h54, 32'h7);
        chk("single_stamp", trace_cycle, 32'd3);
        chk("single_addr", trace_addr, 32'h54);
        memwrite = 1'b0;
        trace_ready = 1'b1;
        step();
        chk("single_popped", 32'(trace_valid), 32'd0);

        // Back-pressure: five stores into a four-entry FIFO
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
        store(32'h110, 32'hA4);
        store(32'h110, 32'hA4);
        chk("bp_stalls", stall_count, 32'd3);
        trace_ready = 1'b1;
        store(32'h110, 32'hA4);
        chk("bp_head_after_pop", trace_cycle, 32'd2);
        memwrite = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_drained", 32'(trace_valid), 32'd0);

        // Randomized traffic with wrap-around and random back-pressure
        for (int i = 0; i < 400; i++) begin
            memwrite    = 1'($urandom_range(0, 1));
            aluout      = $urandom;
            writedata   = $urandom;
            trace_ready = ($urandom_range(0, 9) < 6);
            pc          = 32'($urandom_range(0, 16'hFFFF));
            step();
        end

        // Finish masking with two entries queued
        memwrite = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        trace_ready = 1'b0;
        store(32'h200, 32'h11);
        store(32'h204, 32'h22);
        pc_finished = 32'h0000_0400;
        pc = 32'h0000_0400;
        store(32'h208, 32'h33);
        chk("fin_masked_head", trace_addr, 32'h200);
        memwrite = 1'b0;
        trace_ready = 1'b1;
        step();
        chk("fin_not_done", 32'(done), 32'd0);
        step();
        chk("fin_done", 32'(done), 32'd1);
        store(32'h20C, 32'h44);
        step();

        // Finish with an empty FIFO: HALT then DONE on the following edge
        do_reset();
        pc = 32'h0;
        step();
        pc = 32'h0000_0400;
        step();
        chk("empty_halt", 32'(halted), 32'd1);
        step();
        chk("empty_done", 32'(done), 32'd1);

        // Reset while halted with three entries queued
        do_reset();
        pc = 32'h0;
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h300 + 32'(i), 32'h55 + 32'(i));
        memwrite = 1'b0;
        pc = 32'h0000_0400;
        step();
        do_reset();
        pc = 32'h0;
        store(32'h3F0, 32'h99);
        chk("post_reset_stamp", trace_cycle, 32'd1);
        memwrite = 1'b0;
        trace_ready = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
